// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory-port arbiter.
// Holds the FSM encoding, stall vectors and access-size codes.
package mem_port_arbiter_pkg;

  localparam int MASK_WIDTH  = 2;
  localparam int STALL_WIDTH = 6;

  localparam logic [MASK_WIDTH-1:0] MASK_BYTE = 2'b00;
  localparam logic [MASK_WIDTH-1:0] MASK_HALF = 2'b01;
  localparam logic [MASK_WIDTH-1:0] MASK_WORD = 2'b10;

  // Bit order: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB
  localparam logic [STALL_WIDTH-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_WIDTH-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_WIDTH-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_IF_BUSY  = 3'd1,
    ST_MEM_BUSY = 3'd2,
    ST_RESP_IF  = 3'd3,
    ST_RESP_MEM = 3'd4
  } arb_state_e;

  function automatic logic is_busy(input arb_state_e s);
    return (s == ST_IF_BUSY) || (s == ST_MEM_BUSY);
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Bus-transaction timeout counter; cleared outside a transaction, counts while enabled.
// expired is high in the last allowed cycle so the arbiter leaves BUSY on that edge.
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = enable && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory bus arbiter between instruction fetch and the MEM stage; MEM wins ties.
// Optional bus watchdog and sticky err flag are enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [ADDR_W-1:0]      if_addr,
  output logic                   if_ready,
  output logic [DATA_W-1:0]      if_rdata,
  input  logic                   mem_req,
  input  logic                   mem_we,
  input  logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_wdata,
  input  logic [MASK_WIDTH-1:0]  mem_mask,
  output logic                   mem_ready,
  output logic [DATA_W-1:0]      mem_rdata,
  output logic                   bus_req,
  output logic                   bus_we,
  output logic [ADDR_W-1:0]      bus_addr,
  output logic [DATA_W-1:0]      bus_wdata,
  output logic [MASK_WIDTH-1:0]  bus_mask,
  input  logic                   bus_ack,
  input  logic [DATA_W-1:0]      bus_rdata,
  output logic [STALL_WIDTH-1:0] stall,
  output logic                   err
);

  arb_state_e            state_q, state_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]     bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]     bus_wdata_q, bus_wdata_d;
  logic [MASK_WIDTH-1:0] bus_mask_q, bus_mask_d;
  logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]     mem_rdata_q, mem_rdata_d;
  logic                  busy;
  logic                  wd_expired;
  logic [STALL_WIDTH-1:0] stall_c;

  assign busy = is_busy(state_q);

`ifdef ARB_TIMEOUT_EN
  logic err_q, err_d;
  logic unused_addr_bits;

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (!busy),
    .enable  (busy),
    .expired (wd_expired)
  );

  assign err_d = err_q | wd_expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err              = err_q;
  assign unused_addr_bits = ^if_addr[1:0];
`else
  logic unused_bits;

  assign wd_expired  = 1'b0;
  assign err         = 1'b0;
  assign unused_bits = ^{if_addr[1:0], wd_expired, 32'(TIMEOUT_CYCLES)};
`endif

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_mask_d  = bus_mask_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          state_d     = ST_MEM_BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
          bus_mask_d  = mem_mask;
        end else if (if_req) begin
          state_d    = ST_IF_BUSY;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = {if_addr[ADDR_W-1:2], 2'b00};
          bus_mask_d = MASK_WORD;
        end
      end
      ST_IF_BUSY: begin
        if (bus_ack) begin
          state_d    = ST_RESP_IF;
          bus_req_d  = 1'b0;
          if_rdata_d = bus_rdata;
        end
`ifdef ARB_TIMEOUT_EN
        else if (wd_expired) begin
          state_d    = ST_RESP_IF;
          bus_req_d  = 1'b0;
          if_rdata_d = '0;
        end
`endif
      end
      ST_MEM_BUSY: begin
        // Stores capture bus_rdata too so mem_rdata is always deterministic
        if (bus_ack) begin
          state_d     = ST_RESP_MEM;
          bus_req_d   = 1'b0;
          mem_rdata_d = bus_rdata;
        end
`ifdef ARB_TIMEOUT_EN
        else if (wd_expired) begin
          state_d     = ST_RESP_MEM;
          bus_req_d   = 1'b0;
          mem_rdata_d = '0;
        end
`endif
      end
      // RESP states never grant: the requester still holds its request this cycle
      ST_RESP_IF:  state_d = ST_IDLE;
      ST_RESP_MEM: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_mask_q  <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_mask_q  <= bus_mask_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Reset forces stall low even while the pipeline still asserts a request
  always_comb begin
    stall_c = STALL_NONE;
    if (!rst) begin
      stall_c = STALL_NONE;
    end else if (mem_req && (state_q != ST_RESP_MEM)) begin
      stall_c = STALL_MEM;
    end else if (if_req && (state_q != ST_RESP_IF)) begin
      stall_c = STALL_IF;
    end
  end

  assign stall     = stall_c;
  assign if_ready  = (state_q == ST_RESP_IF);
  assign mem_ready = (state_q == ST_RESP_MEM);
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_mask  = bus_mask_q;

  a_if_req_held: assert property (@(posedge clk) disable iff (!rst)
    (state_q == ST_IF_BUSY) |-> if_req);
  a_mem_req_held: assert property (@(posedge clk) disable iff (!rst)
    (state_q == ST_MEM_BUSY) |-> mem_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, priority, delayed store, reset, back-to-back.
// The timeout scenario is compiled in when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_mask;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [1:0]  bus_mask;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [5:0]  stall;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_mask(bus_mask), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall(stall), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0;
    mem_addr = '0; mem_wdata = '0; mem_mask = '0; bus_ack = 0; bus_rdata = '0;
    #2;
    total++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, bus_mask} !== 68'd0) begin
      bad++; $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h mask=%b want all 0",
                      bus_req, bus_we, bus_addr, bus_wdata, bus_mask);
    end
    total++;
    if ({if_ready, mem_ready, if_rdata, mem_rdata, err, stall} !== 73'd0) begin
      bad++; $display("FAIL reset_out: got ifr=%b memr=%b ifd=%h memd=%h err=%b stall=%b want all 0",
                      if_ready, mem_ready, if_rdata, mem_rdata, err, stall);
    end
    mem_req = 1'b1;
    #1;
    total++;
    if (stall !== 6'b000000) begin
      bad++; $display("FAIL reset_stall: got %b want 000000", stall);
    end
    mem_req = 1'b0;
    step(); step();
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_if_only();
    if_req = 1'b1; if_addr = 32'h0000_1006;
    @(negedge clk);
    total++;
    if ({bus_req, stall} !== {1'b0, 6'b000011}) begin
      bad++; $display("FAIL if_wait: got req=%b stall=%b want 0/000011", bus_req, stall);
    end
    step();
    bus_ack = 1'b1; bus_rdata = 32'h0051_0113;
    @(negedge clk);
    total++;
    if ({bus_req, bus_we, bus_addr, bus_mask} !== {1'b1, 1'b0, 32'h0000_1004, 2'b10}) begin
      bad++; $display("FAIL if_grant: got req=%b we=%b addr=%h mask=%b want 1/0/00001004/10",
                      bus_req, bus_we, bus_addr, bus_mask);
    end
    total++;
    if ({stall, if_ready} !== {6'b000011, 1'b0}) begin
      bad++; $display("FAIL if_busy_stall: got stall=%b rdy=%b want 000011/0", stall, if_ready);
    end
    step();
    bus_ack = 1'b0; bus_rdata = '0;
    @(negedge clk);
    total++;
    if ({if_ready, if_rdata, stall, bus_req} !== {1'b1, 32'h0051_0113, 6'b000000, 1'b0}) begin
      bad++; $display("FAIL if_resp: got rdy=%b data=%h stall=%b req=%b want 1/00510113/000000/0",
                      if_ready, if_rdata, stall, bus_req);
    end
    step();
    if_req = 1'b0;
    @(negedge clk);
    total++;
    if ({if_ready, bus_req} !== 2'b00) begin
      bad++; $display("FAIL if_pulse_end: got rdy=%b req=%b want 0/0", if_ready, bus_req);
    end
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 32'h0000_100B;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_2000; mem_mask = 2'b00;
    @(negedge clk);
    total++;
    if (stall !== 6'b011111) begin
      bad++; $display("FAIL both_idle_stall: got %b want 011111", stall);
    end
    step();
    bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
    @(negedge clk);
    total++;
    if ({bus_req, bus_we, bus_addr, bus_mask, stall} !== {1'b1, 1'b0, 32'h0000_2000, 2'b00, 6'b011111}) begin
      bad++; $display("FAIL mem_first: got req=%b we=%b addr=%h mask=%b stall=%b want 1/0/00002000/00/011111",
                      bus_req, bus_we, bus_addr, bus_mask, stall);
    end
    step();
    bus_ack = 1'b0; bus_rdata = '0;
    @(negedge clk);
    total++;
    if ({mem_ready, mem_rdata, if_ready, stall} !== {1'b1, 32'h1122_3344, 1'b0, 6'b000011}) begin
      bad++; $display("FAIL mem_resp: got rdy=%b data=%h ifr=%b stall=%b want 1/11223344/0/000011",
                      mem_ready, mem_rdata, if_ready, stall);
    end
    mem_req = 1'b0;
    step();
    @(negedge clk);
    total++;
    if ({bus_req, stall} !== {1'b0, 6'b000011}) begin
      bad++; $display("FAIL if_after_mem_idle: got req=%b stall=%b want 0/000011", bus_req, stall);
    end
    step();
    bus_ack = 1'b1; bus_rdata = 32'h0000_0013;
    @(negedge clk);
    total++;
    if ({bus_req, bus_we, bus_addr, bus_mask} !== {1'b1, 1'b0, 32'h0000_1008, 2'b10}) begin
      bad++; $display("FAIL if_second: got req=%b we=%b addr=%h mask=%b want 1/0/00001008/10",
                      bus_req, bus_we, bus_addr, bus_mask);
    end
    step();
    bus_ack = 1'b0;
    @(negedge clk);
    total++;
    if ({if_ready, if_rdata} !== {1'b1, 32'h0000_0013}) begin
      bad++; $display("FAIL if_second_resp: got rdy=%b data=%h want 1/00000013", if_ready, if_rdata);
    end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_store_delayed();
    int pulses = 0;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_3000;
    mem_wdata = 32'hDEAD_BEEF; mem_mask = 2'b01; bus_rdata = 32'hCAFE_0001;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({bus_req, bus_we, bus_addr, bus_wdata, bus_mask} !==
          {1'b1, 1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 2'b01}) begin
        bad++; $display("FAIL store_hold[%0d]: got req=%b we=%b addr=%h wdata=%h mask=%b want 1/1/00003000/deadbeef/01",
                        i, bus_req, bus_we, bus_addr, bus_wdata, bus_mask);
      end
      pulses += int'(mem_ready);
      step();
    end
    bus_ack = 1'b1;
    @(negedge clk);
    pulses += int'(mem_ready);
    step();
    bus_ack = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_ready, mem_rdata, bus_req} !== {1'b1, 32'hCAFE_0001, 1'b0}) begin
      bad++; $display("FAIL store_resp: got rdy=%b data=%h req=%b want 1/cafe0001/0",
                      mem_ready, mem_rdata, bus_req);
    end
    pulses += int'(mem_ready);
    mem_req = 1'b0; mem_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      pulses += int'(mem_ready);
    end
    total++;
    if (pulses !== 1) begin
      bad++; $display("FAIL store_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    step();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_4000; mem_mask = 2'b10;
    step();
    @(negedge clk);
    total++;
    if (bus_req !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre: got req=%b want 1", bus_req);
    end
    #1 rst = 1'b0;
    #1;
    total++;
    if ({bus_req, stall} !== {1'b0, 6'b000000}) begin
      bad++; $display("FAIL rstmid_drop: got req=%b stall=%b want 0/000000", bus_req, stall);
    end
    step();
    mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stray += int'(mem_ready) + int'(if_ready) + int'(bus_req);
      step();
    end
    bus_ack = 1'b0;
    total++;
    if (stray !== 0) begin
      bad++; $display("FAIL rstmid_stale_ack: got %0d ready/req events want 0", stray);
    end
  endtask

  task automatic test_back_to_back();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_5004; mem_mask = 2'b10;
    step();
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
    step();
    bus_ack = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_ready, bus_req, stall} !== {1'b1, 1'b0, 6'b000000}) begin
      bad++; $display("FAIL b2b_resp: got rdy=%b req=%b stall=%b want 1/0/000000",
                      mem_ready, bus_req, stall);
    end
    step();
    @(negedge clk);
    total++;
    if ({bus_req, mem_ready, stall} !== {1'b0, 1'b0, 6'b011111}) begin
      bad++; $display("FAIL b2b_no_reissue: got req=%b rdy=%b stall=%b want 0/0/011111",
                      bus_req, mem_ready, stall);
    end
    mem_req = 1'b0;
    step();
    @(negedge clk);
    total++;
    if (bus_req !== 1'b0) begin
      bad++; $display("FAIL b2b_idle: got req=%b want 0", bus_req);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int  high = 0;
    logic dropped = 1'b0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_6000; mem_mask = 2'b10;
    step();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus_req) begin
        dropped = 1'b1;
        break;
      end
      high++;
      step();
    end
    total++;
    if (!dropped || high != 8) begin
      bad++; $display("FAIL timeout_len: got dropped=%b cycles=%0d want 1/8", dropped, high);
    end
    total++;
    if ({mem_ready, mem_rdata, err} !== {1'b1, 32'h0, 1'b1}) begin
      bad++; $display("FAIL timeout_resp: got rdy=%b data=%h err=%b want 1/00000000/1",
                      mem_ready, mem_rdata, err);
    end
    mem_req = 1'b0;
    step(); step();
    @(negedge clk);
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL timeout_sticky: got err=%b want 1", err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_if_only();
    test_simultaneous();
    test_store_delayed();
    test_reset_mid();
    test_back_to_back();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    @(negedge clk);
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL err_tied: got %b want 0", err);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
